synth_cfg_writer: RTL and testbench

SYNTH_CFG_WRITER -- requirements
Module: synth_cfg_writer

---
 rtl/synth_cfg_writer.sv | 197 +++++++++++++++++++
 tb/tb_synth_cfg_writer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/synth_cfg_writer.sv
// rtl/synth_cfg_writer.sv - serialises a masked 6-byte config image onto a synth's byte-wide cfg bus
//
// Purpose:
//   Accepts one write request (6-bit byte mask + 48-bit image) from the host
//   and emits the selected bytes one per cycle in ascending index order. Each
//   emitted byte is marked by a one-hot cfg_en strobe. An optional run of
//   GAP_CYCLES idle cycles separates consecutive bytes.
//
// Parameters:
//   GAP_CYCLES  idle cycles between consecutive emitted bytes (0..15)
//
// Build option:
//   SYNTH_CFGW_SHADOW_EN  when defined, a shadow copy of the synth config is
//                         kept and bytes whose value already matches the
//                         shadow are dropped from the request.
//
// Ports:
//   clk        clock, all state on the rising edge
//   rst_n      asynchronous active-low reset
//   ena        global enable; low freezes the sequencer
//   req_valid  host request valid
//   req_ready  writer can accept a request (registered)
//   req_mask   byte select, bit i selects config byte i
//   req_data   config image, byte i = req_data[8i+7:8i]
//   cfg_out    config byte to the synth (holds last emitted value)
//   cfg_en     one-hot byte write strobe, bits 7:6 always 0
//   busy       high while a request is being emitted
//   done       one-cycle pulse when a request completes

module synth_cfg_writer #(
  parameter int GAP_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_mask,
  input  logic [47:0] req_data,
  output logic [7:0]  cfg_out,
  output logic [7:0]  cfg_en,
  output logic        busy,
  output logic        done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  // The gap counter counts down to zero, so it is loaded with one less than
  // the gap length; the byte after the gap is launched on the zero cycle.
  localparam int         GAP_M1   = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam logic [3:0] GAP_LOAD = 4'(GAP_M1);

  logic [1:0]  state;
  logic [5:0]  mask_q;     // bytes still to be emitted
  logic [47:0] data_q;     // latched config image
  logic [3:0]  gap_cnt;

  logic        accept;
  logic [5:0]  eff_mask;
  logic [5:0]  src_mask;
  logic [47:0] src_data;
  logic [5:0]  pick;
  logic [7:0]  pick_byte;

`ifdef SYNTH_CFGW_SHADOW_EN
  logic [47:0] shadow_q;
  logic [5:0]  diff;

  always_comb begin
    diff = '0;
    for (int i = 0; i < 6; i++) begin
      diff[i] = (req_data[8*i +: 8] != shadow_q[8*i +: 8]);
    end
  end

  assign eff_mask = req_mask & diff;
`else
  assign eff_mask = req_mask;
`endif

  // req_ready is only ever high in IDLE; ena is re-checked because
  // req_ready reflects the enable of the previous cycle.
  assign accept = ena & req_valid & req_ready & (state == S_IDLE);

  // The first byte is launched on the accept edge itself, straight from the
  // request inputs; later bytes come from the latched copies.
  assign src_mask = accept ? eff_mask : mask_q;
  assign src_data = accept ? req_data : data_q;

  // Isolate the lowest set bit: ascending emission order.
  assign pick = src_mask & (~src_mask + 6'd1);

  always_comb begin
    pick_byte = '0;
    for (int i = 0; i < 6; i++) begin
      if (pick[i]) begin
        pick_byte = pick_byte | src_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      mask_q    <= '0;
      data_q    <= '0;
      gap_cnt   <= '0;
      cfg_out   <= '0;
      cfg_en    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      req_ready <= 1'b0;
`ifdef SYNTH_CFGW_SHADOW_EN
      shadow_q  <= 48'h0838_0638_0638;
`endif
    end else begin
      // Strobes default low every cycle, including frozen cycles, so a byte
      // strobe or done pulse is never stretched by ena.
      cfg_en <= '0;
      done   <= 1'b0;

      if (!ena) begin
        req_ready <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            req_ready <= 1'b1;
            if (accept) begin
              data_q <= req_data;
              if (eff_mask == 6'd0) begin
                // Nothing to write: acknowledge with done and stay idle.
                mask_q <= '0;
                done   <= 1'b1;
              end else begin
                cfg_en    <= {2'b00, pick};
                cfg_out   <= pick_byte;
                mask_q    <= src_mask & ~pick;
                state     <= S_SEND;
                busy      <= 1'b1;
                req_ready <= 1'b0;
              end
            end
          end

          // A byte is on the bus this cycle; decide what follows it.
          S_SEND: begin
            if (mask_q == 6'd0) begin
              state     <= S_IDLE;
              busy      <= 1'b0;
              done      <= 1'b1;
              req_ready <= 1'b1;
            end else if (GAP_CYCLES > 0) begin
              state   <= S_GAP;
              gap_cnt <= GAP_LOAD;
            end else begin
              cfg_en  <= {2'b00, pick};
              cfg_out <= pick_byte;
              mask_q  <= src_mask & ~pick;
            end
          end

          S_GAP: begin
            if (gap_cnt == 4'd0) begin
              cfg_en  <= {2'b00, pick};
              cfg_out <= pick_byte;
              mask_q  <= src_mask & ~pick;
              state   <= S_SEND;
            end else begin
              gap_cnt <= gap_cnt - 4'd1;
            end
          end

          default: begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            req_ready <= 1'b0;
          end
        endcase

`ifdef SYNTH_CFGW_SHADOW_EN
        // Track what the synth now holds for every byte launched this edge.
        if (accept || (state == S_GAP && gap_cnt == 4'd0) ||
            (state == S_SEND && mask_q != 6'd0 && GAP_CYCLES == 0)) begin
          for (int i = 0; i < 6; i++) begin
            if (pick[i]) begin
              shadow_q[8*i +: 8] <= src_data[8*i +: 8];
            end
          end
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_synth_cfg_writer.sv
// tb/tb_synth_cfg_writer.sv - self-checking bench for synth_cfg_writer (GAP 0 and GAP 2 instances)

module tb_synth_cfg_writer;

  typedef struct {
    logic [5:0]  mask;
    logic [47:0] data;
    int          lat;     // accept cycle to done cycle, without stall
    int          st_at;   // cycle offset at which ena drops
    int          st_len;  // number of frozen cycles, 0 = none
  } vec_t;

  typedef struct {
    logic [7:0] en;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena;

  logic        req_valid0, req_ready0, busy0, done0;
  logic [5:0]  req_mask0;
  logic [47:0] req_data0;
  logic [7:0]  cfg_out0, cfg_en0;

  logic        req_valid2, req_ready2, busy2, done2;
  logic [5:0]  req_mask2;
  logic [47:0] req_data2;
  logic [7:0]  cfg_out2, cfg_en2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pulses0 = 0;

  exp_t q0[$];
  exp_t q2[$];
  exp_t e0, e2;
  vec_t tv[7];
  logic [47:0] shadow_m;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  synth_cfg_writer #(.GAP_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .req_valid(req_valid0), .req_ready(req_ready0),
    .req_mask(req_mask0), .req_data(req_data0),
    .cfg_out(cfg_out0), .cfg_en(cfg_en0), .busy(busy0), .done(done0)
  );

  synth_cfg_writer #(.GAP_CYCLES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .req_valid(req_valid2), .req_ready(req_ready2),
    .req_mask(req_mask2), .req_data(req_data2),
    .cfg_out(cfg_out2), .cfg_en(cfg_en2), .busy(busy2), .done(done2)
  );

  // Scoreboard monitors: every strobe must match the head of the queue.
  always @(negedge clk) begin
    if (cfg_en0 != 8'h00) begin
      pulses0++;
      checks++;
      if (q0.size() == 0) begin
        errors++;
        $display("FAIL byte0_unexpected en=%h out=%h cyc=%0d", cfg_en0, cfg_out0, cyc);
      end else begin
        e0 = q0.pop_front();
        if (cfg_en0 !== e0.en || cfg_out0 !== e0.data || cyc != e0.cyc) begin
          errors++;
          $display("FAIL byte0 got en=%h out=%h cyc=%0d want en=%h out=%h cyc=%0d",
                   cfg_en0, cfg_out0, cyc, e0.en, e0.data, e0.cyc);
        end
      end
    end
    if (done0) begin
      checks++;
      if (cfg_en0 != 8'h00) begin
        errors++;
        $display("FAIL done0_with_en en=%h want 00", cfg_en0);
      end
    end
  end

  always @(negedge clk) begin
    if (cfg_en2 != 8'h00) begin
      checks++;
      if (q2.size() == 0) begin
        errors++;
        $display("FAIL byte2_unexpected en=%h out=%h cyc=%0d", cfg_en2, cfg_out2, cyc);
      end else begin
        e2 = q2.pop_front();
        if (cfg_en2 !== e2.en || cfg_out2 !== e2.data || cyc != e2.cyc) begin
          errors++;
          $display("FAIL byte2 got en=%h out=%h cyc=%0d want en=%h out=%h cyc=%0d",
                   cfg_en2, cfg_out2, cyc, e2.en, e2.data, e2.cyc);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  // Reference model: effective mask, expected byte stream with cycle stamps.
  task automatic push_exp0(input int t, input logic [5:0] m, input logic [47:0] d,
                           input int st_at, input int st_len, output int n);
    int c;
    n = 0;
    for (int i = 0; i < 6; i++) begin
`ifdef SYNTH_CFGW_SHADOW_EN
      if (m[i] && d[8*i +: 8] != shadow_m[8*i +: 8]) begin
        shadow_m[8*i +: 8] = d[8*i +: 8];
`else
      if (m[i]) begin
`endif
        c = t + 1 + n;
        if (st_len > 0 && c > t + st_at) c += st_len;
        q0.push_back('{en: 8'(1 << i), data: d[8*i +: 8], cyc: c});
        n++;
      end
    end
  endtask

  task automatic run0(input logic [5:0] m, input logic [47:0] d, input int lat,
                      input int st_at, input int st_len);
    int t, n, wd;
    bit busy_seen;
    @(negedge clk);
    req_mask0 = m; req_data0 = d; req_valid0 = 1'b1;
    wd = 0;
    while (!req_ready0 && wd < 20) begin @(negedge clk); wd++; end
    checks++;
    if (!req_ready0) begin
      errors++;
      $display("FAIL accept_timeout ready=%b want 1", req_ready0);
      req_valid0 = 1'b0;
      return;
    end
    t = cyc;
    push_exp0(t, m, d, st_at, st_len, n);
    if (st_len > 0) lat += st_len;
    @(negedge clk);
    req_valid0 = 1'b0;
    busy_seen = 1'b0;
    wd = 0;
    while (!done0 && wd < 60) begin
      if (busy0) busy_seen = 1'b1;
      if (st_len > 0 && cyc == t + st_at) ena = 1'b0;
      if (st_len > 0 && cyc == t + st_at + st_len) ena = 1'b1;
      @(negedge clk);
      wd++;
    end
    ena = 1'b1;
    check("done_cycle", 64'(done0 ? cyc - t : -1), 64'(lat));
    check("ready_at_done", 64'(req_ready0), 64'd1);
    check("queue_drained", 64'(q0.size()), 64'd0);
    if (n == 0) check("busy_never", 64'(busy_seen), 64'd0);
  endtask

  initial begin
    int t, wd, p;

    tv[0] = '{mask: 6'h3F, data: 48'hA5A4A3A2A1A0, lat: 7,  st_at: 0, st_len: 0};
    tv[1] = '{mask: 6'h00, data: 48'h123456789ABC, lat: 1,  st_at: 0, st_len: 0};
    tv[2] = '{mask: 6'h21, data: 48'h110000000022, lat: 3,  st_at: 0, st_len: 0};
    tv[3] = '{mask: 6'h2A, data: 48'h990077005500, lat: 4,  st_at: 0, st_len: 0};
    tv[4] = '{mask: 6'h01, data: 48'h0000000000C1, lat: 2,  st_at: 0, st_len: 0};
    tv[5] = '{mask: 6'h20, data: 48'hD70000000000, lat: 2,  st_at: 0, st_len: 0};
    tv[6] = '{mask: 6'h3F, data: 48'h0F1E2D3C4B5A, lat: 7,  st_at: 2, st_len: 3};

    ena = 1'b1; rst_n = 1'b0;
    req_valid0 = 1'b0; req_mask0 = '0; req_data0 = '0;
    req_valid2 = 1'b0; req_mask2 = '0; req_data2 = '0;
    shadow_m = 48'h0838_0638_0638;

    repeat (2) @(negedge clk);
    check("reset_outs0", {cfg_out0, cfg_en0, 5'd0, req_ready0, busy0, done0}, 64'd0);
    check("reset_outs2", {cfg_out2, cfg_en2, 5'd0, req_ready2, busy2, done2}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", {req_ready0, req_ready2}, 64'b11);

`ifdef SYNTH_CFGW_SHADOW_EN
    run0(6'h3F, 48'h083806380638, 1, 0, 0);
    run0(6'h3F, 48'h083806380639, 2, 0, 0);
`endif

    // ena low in IDLE: ready drops and a held request is not taken.
    ena = 1'b0; req_mask0 = 6'h01; req_data0 = 48'h55; req_valid0 = 1'b1;
    @(negedge clk);
    check("ready_ena_low", 64'(req_ready0), 64'd0);
    req_valid0 = 1'b0; ena = 1'b1;
    @(negedge clk);
    check("ready_ena_back", 64'(req_ready0), 64'd1);

    for (int i = 0; i < 7; i++) begin
      run0(tv[i].mask, tv[i].data, tv[i].lat, tv[i].st_at, tv[i].st_len);
    end

    // GAP_CYCLES=2: two idle cycles between the two bytes.
    @(negedge clk);
    req_mask2 = 6'b100001; req_data2 = 48'h110000000022; req_valid2 = 1'b1;
    wd = 0;
    while (!req_ready2 && wd < 20) begin @(negedge clk); wd++; end
    t = cyc;
    q2.push_back('{en: 8'h01, data: 8'h22, cyc: t + 1});
    q2.push_back('{en: 8'h20, data: 8'h11, cyc: t + 4});
    @(negedge clk);
    req_valid2 = 1'b0;
    wd = 0;
    while (!done2 && wd < 40) begin @(negedge clk); wd++; end
    check("gap2_done_cycle", 64'(done2 ? cyc - t : -1), 64'd5);
    check("gap2_drained", 64'(q2.size()), 64'd0);

    // Reset while byte 3 is on the bus: remaining bytes abandoned.
    @(negedge clk);
    req_mask0 = 6'h3F; req_data0 = 48'h5A5B5C5D5E5F; req_valid0 = 1'b1;
    wd = 0;
    while (!req_ready0 && wd < 20) begin @(negedge clk); wd++; end
    t = cyc;
    push_exp0(t, 6'h3F, 48'h5A5B5C5D5E5F, 0, 0, p);
    @(negedge clk);
    req_valid0 = 1'b0;
    while (cyc < t + 4) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_outs", {cfg_out0, cfg_en0, 5'd0, req_ready0, busy0, done0}, 64'd0);
    check("abandoned_bytes", 64'(q0.size()), 64'd2);
    q0.delete();
    shadow_m = 48'h0838_0638_0638;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    p = pulses0;
    @(negedge clk);
    check("ready_after_midreset", 64'(req_ready0), 64'd1);
    repeat (10) @(negedge clk);
    check("no_bytes_after_reset", 64'(pulses0 - p), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
